// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU and the ALU control decoder:
// operation codes and the iterative-ALU state encoding.
package alu_pkg;

  localparam logic [2:0] CTRL_ADD = 3'b000;
  localparam logic [2:0] CTRL_SUB = 3'b001;
  localparam logic [2:0] CTRL_MUL = 3'b010;
  localparam logic [2:0] CTRL_OR  = 3'b100;
  localparam logic [2:0] CTRL_AND = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/mul_iter.sv
// Shift-add multiplier datapath: one partial product per step, low WIDTH bits kept.
// o_acc_next is the accumulator value after the current step (the product on the last step).
module mul_iter #(
  parameter int WIDTH = 32,
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_mcand,
  input  logic [WIDTH-1:0] i_mplr,
  output logic             o_last,
  output logic [WIDTH-1:0] o_acc_next
);
  import alu_pkg::*;

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplr;
  logic [CW-1:0]    r_cnt;

  assign o_acc_next = r_acc + (r_mplr[0] ? r_mcand : {WIDTH{1'b0}});
  assign o_last     = (r_cnt == LAST_CNT);

  // Operand capture on load, one shift-add iteration per step.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc   <= {WIDTH{1'b0}};
      r_mcand <= {WIDTH{1'b0}};
      r_mplr  <= {WIDTH{1'b0}};
      r_cnt   <= {CW{1'b0}};
    end else if (i_load) begin
      r_acc   <= {WIDTH{1'b0}};
      r_mcand <= i_mcand;
      r_mplr  <= i_mplr;
      r_cnt   <= {CW{1'b0}};
    end else if (i_step) begin
      r_acc   <= o_acc_next;
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
      r_cnt   <= r_cnt + 1'b1;
    end else begin
      r_acc   <= r_acc;
      r_mcand <= r_mcand;
      r_mplr  <= r_mplr;
      r_cnt   <= r_cnt;
    end
  end

endmodule

// File: rtl/alu_iter.sv
// Multi-cycle execute-stage ALU: ADD/SUB/OR/AND in one cycle, MUL over WIDTH cycles.
// Result, zero flag and done pulse are registered; busy_o decodes the state register.
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       ALU_control_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             busy_o,
  output logic             done_o
);
  import alu_pkg::*;

  alu_state_e       r_state;
  alu_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic             r_zero;
  logic             r_done;
  logic             w_load;
  logic             w_step;
  logic             w_upd;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_alu;
  logic             w_last;
  logic [WIDTH-1:0] w_mul_res;

  function automatic logic [WIDTH-1:0] alu_single(input logic [2:0]       ctrl,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] res;
    case (ctrl)
      CTRL_ADD: res = a + b;
      CTRL_SUB: res = a - b;
      CTRL_OR:  res = a | b;
      CTRL_AND: res = a & b;
      default:  res = {WIDTH{1'b0}};
    endcase
    return res;
  endfunction

  assign w_alu = alu_single(ALU_control_i, data1_i, data2_i);

  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .i_clk      (clk_i),
    .i_rst_n    (rst_i),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_mcand    (data1_i),
    .i_mplr     (data2_i),
    .o_last     (w_last),
    .o_acc_next (w_mul_res)
  );

  // Next-state and result-update decode; starts are only seen in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_upd       = 1'b0;
    w_res       = r_data;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          if (ALU_control_i == CTRL_MUL) begin
            w_load      = 1'b1;
            w_state_nxt = ST_MUL;
          end else begin
            w_upd = 1'b1;
            w_res = w_alu;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_MUL: begin
        w_step = 1'b1;
        if (w_last) begin
          w_upd       = 1'b1;
          w_res       = w_mul_res;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_MUL;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, result, zero flag and done pulse registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
      r_data  <= {WIDTH{1'b0}};
      r_zero  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_upd;
      if (w_upd) begin
        r_data <= w_res;
        r_zero <= (w_res == {WIDTH{1'b0}});
      end else begin
        r_data <= r_data;
        r_zero <= r_zero;
      end
    end
  end

  assign data_o = r_data;
  assign zero_o = r_zero;
  assign done_o = r_done;
  assign busy_o = (r_state == ST_MUL);

endmodule

// File: tb/tb_alu_iter.sv
// Directed-vector bench for alu_iter with hand-computed expected results.
module tb_alu_iter;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [2:0]  ALU_control_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic [31:0] data_o;
  logic        zero_o;
  logic        busy_o;
  logic        done_o;

  int n_vec;
  int n_err;

  alu_iter #(.WIDTH(32)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .ALU_control_i (ALU_control_i),
    .data1_i       (data1_i),
    .data2_i       (data2_i),
    .data_o        (data_o),
    .zero_o        (zero_o),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i       = 1'b1;
    ALU_control_i = op;
    data1_i       = a;
    data2_i       = b;
  endtask

  // Call right after the accepting edge; lat counts the accepting edge as cycle 1.
  task automatic wait_done(input logic [31:0] old_data, output int lat, output int busy_n,
                           output int chg, output bit got);
    lat    = 1;
    busy_n = 0;
    chg    = 0;
    got    = 1'b0;
    while (!got && lat <= 60) begin
      if (done_o) begin
        got = 1'b1;
      end else begin
        if (busy_o) busy_n++;
        if (data_o !== old_data) chg++;
        tick();
        lat++;
      end
    end
  endtask

  int lat;
  int busy_n;
  int chg;
  bit got;
  int pulses;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_i = 1'b0;
    issue(3'b000, 32'd0, 32'd0);
    start_i = 1'b0;
    tick();
    tick();
    check_eq("rst_data", data_o, 32'h0000_0000);
    check_eq("rst_zero", {31'd0, zero_o}, 32'd1);
    check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("rst_done", {31'd0, done_o}, 32'd0);
    rst_i = 1'b1;
    tick();

    // ADD 5+7 then SUB 5-5
    issue(3'b000, 32'd5, 32'd7);
    tick();
    start_i = 1'b0;
    check_eq("add_done", {31'd0, done_o}, 32'd1);
    check_eq("add_data", data_o, 32'd12);
    check_eq("add_zero", {31'd0, zero_o}, 32'd0);
    check_eq("add_busy", {31'd0, busy_o}, 32'd0);
    tick();
    check_eq("add_done_drop", {31'd0, done_o}, 32'd0);
    issue(3'b001, 32'd5, 32'd5);
    tick();
    start_i = 1'b0;
    check_eq("sub_done", {31'd0, done_o}, 32'd1);
    check_eq("sub_data", data_o, 32'd0);
    check_eq("sub_zero", {31'd0, zero_o}, 32'd1);
    tick();
    check_eq("sub_done_drop", {31'd0, done_o}, 32'd0);

    // OR and AND on consecutive edges
    issue(3'b100, 32'hF0F0_0000, 32'h0000_0F0F);
    tick();
    check_eq("or_done", {31'd0, done_o}, 32'd1);
    check_eq("or_data", data_o, 32'hF0F0_0F0F);
    issue(3'b101, 32'hFF00_FF00, 32'h0FF0_0FF0);
    tick();
    start_i = 1'b0;
    check_eq("and_done", {31'd0, done_o}, 32'd1);
    check_eq("and_data", data_o, 32'h0F00_0F00);
    check_eq("and_zero", {31'd0, zero_o}, 32'd0);
    tick();
    check_eq("and_done_drop", {31'd0, done_o}, 32'd0);

    // MUL 0xFFFFFFFF * 3
    issue(3'b010, 32'hFFFF_FFFF, 32'd3);
    tick();
    start_i = 1'b0;
    check_eq("mul1_busy_rise", {31'd0, busy_o}, 32'd1);
    wait_done(32'h0F00_0F00, lat, busy_n, chg, got);
    check_eq("mul1_done_seen", {31'd0, got}, 32'd1);
    check_eq("mul1_latency", lat, 32'd33);
    check_eq("mul1_busy_cycles", busy_n, 32'd32);
    check_eq("mul1_data_hold", chg, 32'd0);
    check_eq("mul1_data", data_o, 32'hFFFF_FFFD);
    check_eq("mul1_zero", {31'd0, zero_o}, 32'd0);
    check_eq("mul1_busy_fall", {31'd0, busy_o}, 32'd0);

    // MUL 0x10000 * 0x10000 with ADD 1+1 held pending throughout
    issue(3'b010, 32'h0001_0000, 32'h0001_0000);
    tick();
    issue(3'b000, 32'd1, 32'd1);
    wait_done(32'hFFFF_FFFD, lat, busy_n, chg, got);
    check_eq("mul2_done_seen", {31'd0, got}, 32'd1);
    check_eq("mul2_latency", lat, 32'd33);
    check_eq("mul2_data_hold", chg, 32'd0);
    check_eq("mul2_data", data_o, 32'd0);
    check_eq("mul2_zero", {31'd0, zero_o}, 32'd1);
    tick();
    start_i = 1'b0;
    check_eq("held_add_done", {31'd0, done_o}, 32'd1);
    check_eq("held_add_data", data_o, 32'd2);
    check_eq("held_add_zero", {31'd0, zero_o}, 32'd0);
    tick();
    check_eq("held_add_done_drop", {31'd0, done_o}, 32'd0);

    // Asynchronous reset at iteration 10 of MUL 6*7
    issue(3'b010, 32'd6, 32'd7);
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #2;
    rst_i = 1'b0;
    #1;
    check_eq("arst_busy", {31'd0, busy_o}, 32'd0);
    check_eq("arst_done", {31'd0, done_o}, 32'd0);
    check_eq("arst_data", data_o, 32'd0);
    check_eq("arst_zero", {31'd0, zero_o}, 32'd1);
    tick();
    rst_i = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done_o) pulses++;
    end
    check_eq("arst_no_done", pulses, 32'd0);
    issue(3'b010, 32'd6, 32'd7);
    tick();
    start_i = 1'b0;
    wait_done(32'd0, lat, busy_n, chg, got);
    check_eq("mul3_done_seen", {31'd0, got}, 32'd1);
    check_eq("mul3_latency", lat, 32'd33);
    check_eq("mul3_data", data_o, 32'd42);
    check_eq("mul3_zero", {31'd0, zero_o}, 32'd0);
    tick();

    // Illegal code
    issue(3'b111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    start_i = 1'b0;
    check_eq("ill_done", {31'd0, done_o}, 32'd1);
    check_eq("ill_data", data_o, 32'd0);
    check_eq("ill_zero", {31'd0, zero_o}, 32'd1);
    check_eq("ill_busy", {31'd0, busy_o}, 32'd0);
    tick();
    check_eq("ill_done_drop", {31'd0, done_o}, 32'd0);
    check_eq("ill_busy_after", {31'd0, busy_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
